// File: rtl/avalon_uart_fifo_if.sv
// Avalon-MM slave bus plus the link-side valid/ready stream pair of the UART FIFO.
interface avalon_uart_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  avs_chipselect;
  logic [1:0]            avs_address;
  logic                  avs_read_n;
  logic                  avs_write_n;
  logic [31:0]           avs_writedata;
  logic [31:0]           avs_readdata;
  logic                  avs_waitrequest;
  logic                  irq;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;

  modport slave (
    input  avs_chipselect, avs_address, avs_read_n, avs_write_n, avs_writedata,
    input  tx_ready, rx_data, rx_valid,
    output avs_readdata, avs_waitrequest, irq, tx_data, tx_valid, rx_ready
  );

  modport master (
    output avs_chipselect, avs_address, avs_read_n, avs_write_n, avs_writedata,
    output tx_ready, rx_data, rx_valid,
    input  avs_readdata, avs_waitrequest, irq, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/avalon_uart_fifo.sv
// Avalon-MM byte-stream slave: show-ahead TX/RX FIFOs, DATA/CONTROL/THRESH
// registers, threshold interrupts and optional blocking writes on a full TX.
module avalon_uart_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int TX_DEPTH_LOG2 = 6,
  parameter int RX_DEPTH_LOG2 = 6,
  parameter int BLOCKING      = 0
) (
  input logic               clk,
  input logic               reset,
  avalon_uart_fifo_if.slave bus_if
);
  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
  localparam logic [TX_DEPTH_LOG2:0] TX_CAP = (TX_DEPTH_LOG2+1)'(TX_DEPTH);
  localparam logic [RX_DEPTH_LOG2:0] RX_CAP = (RX_DEPTH_LOG2+1)'(RX_DEPTH);
  localparam logic [15:0] TX_TH_RST = 16'(TX_DEPTH / 2);

  logic [DATA_WIDTH-1:0]    tx_mem_q [TX_DEPTH];
  logic [DATA_WIDTH-1:0]    rx_mem_q [RX_DEPTH];
  logic [TX_DEPTH_LOG2-1:0] tx_wr_q, tx_rd_q;
  logic [RX_DEPTH_LOG2-1:0] rx_wr_q, rx_rd_q;
  logic [TX_DEPTH_LOG2:0]   tx_cnt_q, tx_cnt_d, tx_space;
  logic [RX_DEPTH_LOG2:0]   rx_cnt_q, rx_cnt_d;
  logic [31:0]              readdata_q, rd_data_d;
  logic [15:0]              rx_th_q, tx_th_q;
  logic                     rd_ack_q, irq_q, re_q, we_q, ac_q;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic wr_stall, rd_start, wr_fire;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic ri, wi;
  logic unused_wdata;

  // Full/empty come straight from the registered occupancy counters, so a
  // same-cycle pop never frees space for a same-cycle push.
  assign tx_full  = (tx_cnt_q == TX_CAP);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == RX_CAP);
  assign rx_empty = (rx_cnt_q == '0);
  assign tx_space = TX_CAP - tx_cnt_q;

  assign wr_stall = (BLOCKING != 0) && tx_full;
  assign rd_start = bus_if.avs_chipselect & ~bus_if.avs_read_n & ~rd_ack_q;
  assign wr_fire  = bus_if.avs_chipselect & ~bus_if.avs_write_n & ~wr_stall;
  assign tx_push  = wr_fire & (bus_if.avs_address == 2'd0) & ~tx_full;
  assign tx_pop   = ~tx_empty & bus_if.tx_ready;
  assign rx_push  = bus_if.rx_valid & ~rx_full;
  assign rx_pop   = rd_start & (bus_if.avs_address == 2'd0) & ~rx_empty;

  // A threshold of 0 is satisfied by any count, so the non-zero term alone
  // gives the "0 behaves as 1" rule for RI.
  assign ri = (rx_cnt_q != '0) && (32'(rx_cnt_q) >= 32'(rx_th_q));
  assign wi = (32'(tx_space) >= 32'(tx_th_q));

  assign tx_cnt_d = tx_cnt_q + (TX_DEPTH_LOG2+1)'(tx_push) - (TX_DEPTH_LOG2+1)'(tx_pop);
  assign rx_cnt_d = rx_cnt_q + (RX_DEPTH_LOG2+1)'(rx_push) - (RX_DEPTH_LOG2+1)'(rx_pop);

  assign bus_if.avs_waitrequest = bus_if.avs_chipselect &
                                  ((~bus_if.avs_read_n & ~rd_ack_q) |
                                   (~bus_if.avs_write_n & wr_stall));
  assign bus_if.avs_readdata = readdata_q;
  assign bus_if.irq          = irq_q;
  assign bus_if.tx_data      = tx_mem_q[tx_rd_q];
  assign bus_if.tx_valid     = ~tx_empty;
  assign bus_if.rx_ready     = ~rx_full;

  // Only the low DATA_WIDTH bits and a few CONTROL bits are meaningful.
  assign unused_wdata = ^bus_if.avs_writedata;

  // Read-data mux for the addressed register; unused bits read 0.
  always_comb begin
    rd_data_d = '0;
    case (bus_if.avs_address)
      2'd0: begin
        if (!rx_empty) begin
          rd_data_d[DATA_WIDTH-1:0] = rx_mem_q[rx_rd_q];
          rd_data_d[15]             = 1'b1;
          rd_data_d[31:16]          = 16'(rx_cnt_q);
        end
      end
      2'd1: begin
        rd_data_d[0]     = re_q;
        rd_data_d[1]     = we_q;
        rd_data_d[8]     = ri;
        rd_data_d[9]     = wi;
        rd_data_d[10]    = ac_q;
        rd_data_d[31:16] = 16'(tx_space);
      end
      2'd2:    rd_data_d = {tx_th_q, rx_th_q};
      default: rd_data_d = '0;
    endcase
  end

  // FIFO storage; not reset, the pointers and counters define validity.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= bus_if.avs_writedata[DATA_WIDTH-1:0];
    if (rx_push) rx_mem_q[rx_wr_q] <= bus_if.rx_data;
  end

  // Pointers, counters, CPU registers, read handshake and interrupt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      readdata_q <= '0;
      rd_ack_q   <= 1'b0;
      irq_q      <= 1'b0;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      ac_q       <= 1'b0;
      rx_th_q    <= 16'd1;
      tx_th_q    <= TX_TH_RST;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + TX_DEPTH_LOG2'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + TX_DEPTH_LOG2'(1);
      if (rx_push) rx_wr_q <= rx_wr_q + RX_DEPTH_LOG2'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + RX_DEPTH_LOG2'(1);
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      // First read cycle captures data and arms the ack for the second cycle.
      rd_ack_q <= rd_start;
      if (rd_start) readdata_q <= rd_data_d;
      // A non-blocking write that hits a full TX is dropped and flagged.
      if (wr_fire && bus_if.avs_address == 2'd0 && tx_full) ac_q <= 1'b1;
      if (wr_fire && bus_if.avs_address == 2'd1) begin
        re_q <= bus_if.avs_writedata[0];
        we_q <= bus_if.avs_writedata[1];
        if (bus_if.avs_writedata[10]) ac_q <= 1'b0;
      end
      if (wr_fire && bus_if.avs_address == 2'd2) begin
        rx_th_q <= bus_if.avs_writedata[15:0];
        tx_th_q <= bus_if.avs_writedata[31:16];
      end
      irq_q <= (re_q & ri) | (we_q & wi);
    end
  end
endmodule

// File: tb/tb_avalon_uart_fifo.sv
// Self-checking bench for avalon_uart_fifo: a default non-blocking instance
// (depth 64) and a small blocking instance (depth 4) checked against queues.
`timescale 1ns/1ps
module tb_avalon_uart_fifo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  avalon_uart_fifo_if #(.DATA_WIDTH(8)) if_a ();
  avalon_uart_fifo_if #(.DATA_WIDTH(8)) if_b ();

  avalon_uart_fifo #(.DATA_WIDTH(8), .TX_DEPTH_LOG2(6), .RX_DEPTH_LOG2(6), .BLOCKING(0))
    dut_a (.clk(clk), .reset(reset), .bus_if(if_a));
  avalon_uart_fifo #(.DATA_WIDTH(8), .TX_DEPTH_LOG2(2), .RX_DEPTH_LOG2(2), .BLOCKING(1))
    dut_b (.clk(clk), .reset(reset), .bus_if(if_b));

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  logic [7:0] txq_a[$], rxq_a[$], txq_b[$], rxq_b[$];
  logic re_a = 0, we_a = 0, ac_a = 0;
  int   rxth_a = 1, txth_a = 32;

  typedef struct packed {
    logic [1:0]  op;    // 0 write, 1 read, 2 rx push
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  function automatic logic [31:0] ctrl_exp(input logic re, input logic we, input logic ac,
                                           input int rxcnt, input int rxth,
                                           input int txspace, input int txth);
    logic [31:0] v;
    v = '0;
    v[0] = re;
    v[1] = we;
    v[8] = (rxcnt != 0) && (rxcnt >= ((rxth == 0) ? 1 : rxth));
    v[9] = (txspace >= txth);
    v[10] = ac;
    v[31:16] = 16'(txspace);
    return v;
  endfunction

  function automatic logic [31:0] data_exp(input int cnt, input logic [7:0] d);
    if (cnt == 0) return 32'd0;
    return {16'(cnt), 1'b1, 7'd0, d};
  endfunction

  task automatic drive_bus(input int which, input logic cs, input logic [1:0] a,
                           input logic rn, input logic wn, input logic [31:0] wd);
    if (which == 0) begin
      if_a.avs_chipselect = cs; if_a.avs_address = a; if_a.avs_read_n = rn;
      if_a.avs_write_n = wn; if_a.avs_writedata = wd;
    end else begin
      if_b.avs_chipselect = cs; if_b.avs_address = a; if_b.avs_read_n = rn;
      if_b.avs_write_n = wn; if_b.avs_writedata = wd;
    end
  endtask

  task automatic set_rx(input int which, input logic v, input logic [7:0] d);
    if (which == 0) begin if_a.rx_valid = v; if_a.rx_data = d; end
    else begin if_b.rx_valid = v; if_b.rx_data = d; end
  endtask

  task automatic set_txr(input int which, input logic v);
    if (which == 0) if_a.tx_ready = v; else if_b.tx_ready = v;
  endtask

  function automatic logic get_wait(input int which);
    return (which == 0) ? if_a.avs_waitrequest : if_b.avs_waitrequest;
  endfunction
  function automatic logic [31:0] get_rdata(input int which);
    return (which == 0) ? if_a.avs_readdata : if_b.avs_readdata;
  endfunction

  // All bus tasks start and end 1 ns after a rising edge.
  task automatic bus_write(input int which, input logic [1:0] addr, input logic [31:0] data);
    int guard;
    guard = 0;
    drive_bus(which, 1'b1, addr, 1'b1, 1'b0, data);
    #1;
    while (get_wait(which) && guard < 100) begin @(posedge clk); #1; guard++; end
    if (guard >= 100) check("write_timeout", 32'(guard), 32'd0);
    @(posedge clk); #1;
    drive_bus(which, 1'b0, 2'd0, 1'b1, 1'b1, 32'd0);
    $display("wr dut%0d addr=%0d data=%08h stall=%0d", which, addr, data, guard);
  endtask

  task automatic bus_read(input int which, input logic [1:0] addr,
                          output logic [31:0] data, output int waits);
    waits = 0;
    drive_bus(which, 1'b1, addr, 1'b0, 1'b1, 32'd0);
    #1;
    while (get_wait(which) && waits < 100) begin @(posedge clk); #1; waits++; end
    data = get_rdata(which);
    @(posedge clk); #1;
    drive_bus(which, 1'b0, 2'd0, 1'b1, 1'b1, 32'd0);
    $display("rd dut%0d addr=%0d data=%08h waits=%0d", which, addr, data, waits);
  endtask

  task automatic push_rx(input int which, input logic [7:0] d);
    set_rx(which, 1'b1, d);
    @(posedge clk); #1;
    set_rx(which, 1'b0, 8'd0);
    $display("rx dut%0d data=%02h", which, d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int w, sz, rd_phase;
    logic rv;
    logic [7:0] rdat;
    logic [31:0] rd_exp;
    bit done;

    drive_bus(0, 1'b0, 2'd0, 1'b1, 1'b1, 32'd0);
    drive_bus(1, 1'b0, 2'd0, 1'b1, 1'b1, 32'd0);
    set_rx(0, 1'b0, 8'd0); set_rx(1, 1'b0, 8'd0);
    set_txr(0, 1'b0); set_txr(1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // ---- reset in the middle of a read with 3 RX entries ----
    for (int i = 0; i < 3; i++) push_rx(0, 8'(8'h10 + i));
    drive_bus(0, 1'b1, 2'd0, 1'b0, 1'b1, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    #3 reset = 1'b0;
    drive_bus(0, 1'b0, 2'd0, 1'b1, 1'b1, 32'd0);
    rxq_a.delete();
    @(negedge clk);
    check("rst_readdata", if_a.avs_readdata, 32'd0);
    check("rst_irq", 32'(if_a.irq), 32'd0);
    check("rst_rx_ready", 32'(if_a.rx_ready), 32'd1);
    check("rst_tx_valid", 32'(if_a.tx_valid), 32'd0);
    @(posedge clk); #1;
    bus_read(0, 2'd1, d, w);
    check("rst_control", d, ctrl_exp(0, 0, 0, 0, 1, 64, 32));
    bus_read(0, 2'd0, d, w);
    check("rst_data", d, 32'd0);

    // ---- register table ----
    vecs.push_back('{2'd1, 2'd2, 32'h0, 32'h0020_0001});
    vecs.push_back('{2'd1, 2'd3, 32'h0, 32'h0000_0000});
    vecs.push_back('{2'd0, 2'd3, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{2'd1, 2'd3, 32'h0, 32'h0000_0000});
    vecs.push_back('{2'd0, 2'd1, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{2'd1, 2'd1, 32'h0, 32'h0040_0203});
    vecs.push_back('{2'd0, 2'd1, 32'h0, 32'h0});
    vecs.push_back('{2'd1, 2'd1, 32'h0, 32'h0040_0200});
    vecs.push_back('{2'd0, 2'd2, 32'h0041_0000, 32'h0});
    vecs.push_back('{2'd1, 2'd2, 32'h0, 32'h0041_0000});
    vecs.push_back('{2'd1, 2'd1, 32'h0, 32'h0040_0000});
    vecs.push_back('{2'd0, 2'd2, 32'h0, 32'h0});
    vecs.push_back('{2'd1, 2'd1, 32'h0, 32'h0040_0200});
    vecs.push_back('{2'd0, 2'd2, 32'h0020_0001, 32'h0});
    vecs.push_back('{2'd1, 2'd2, 32'h0, 32'h0020_0001});
    vecs.push_back('{2'd2, 2'd0, 32'h55, 32'h0});
    vecs.push_back('{2'd2, 2'd0, 32'hAA, 32'h0});
    vecs.push_back('{2'd1, 2'd0, 32'h0, 32'h0002_8055});
    vecs.push_back('{2'd1, 2'd1, 32'h0, 32'h0040_0300});
    vecs.push_back('{2'd1, 2'd0, 32'h0, 32'h0001_80AA});
    vecs.push_back('{2'd1, 2'd0, 32'h0, 32'h0000_0000});
    vecs.push_back('{2'd1, 2'd1, 32'h0, 32'h0040_0200});
    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        2'd0: bus_write(0, vecs[i].addr, vecs[i].data);
        2'd1: begin
          bus_read(0, vecs[i].addr, d, w);
          check($sformatf("vec%0d_data", i), d, vecs[i].exp);
          check($sformatf("vec%0d_waits", i), 32'(w), 32'd1);
        end
        default: push_rx(0, vecs[i].data[7:0]);
      endcase
    end

    // ---- TX overflow, AC, in-order drain (tx_ready low) ----
    for (int i = 0; i < 65; i++) begin
      bus_write(0, 2'd0, 32'(8'h41 + i));
      if (txq_a.size() < 64) txq_a.push_back(8'(8'h41 + i)); else ac_a = 1;
    end
    bus_read(0, 2'd1, d, w);
    check("tx_full_ctrl", d, ctrl_exp(re_a, we_a, ac_a, rxq_a.size(), rxth_a, 64 - txq_a.size(), txth_a));
    bus_write(0, 2'd1, 32'h0000_0400);
    ac_a = 0;
    bus_read(0, 2'd1, d, w);
    check("ac_clear_ctrl", d, ctrl_exp(re_a, we_a, ac_a, rxq_a.size(), rxth_a, 64 - txq_a.size(), txth_a));
    set_txr(0, 1'b1);
    done = 0;
    for (int k = 0; k < 70 && !done; k++) begin
      @(negedge clk);
      if (txq_a.size() != 0) begin
        check("tx_stream_valid", 32'(if_a.tx_valid), 32'd1);
        check("tx_stream_data", 32'(if_a.tx_data), 32'(txq_a.pop_front()));
      end else begin
        check("tx_drained_valid", 32'(if_a.tx_valid), 32'd0);
        done = 1;
      end
    end
    check("tx_drain_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    set_txr(0, 1'b0);

    // ---- RX threshold interrupt ----
    bus_write(0, 2'd2, 32'h0020_0004); rxth_a = 4; txth_a = 32;
    bus_write(0, 2'd1, 32'h1); re_a = 1;
    for (int i = 0; i < 3; i++) begin push_rx(0, 8'(8'hC0 + i)); rxq_a.push_back(8'(8'hC0 + i)); end
    repeat (2) @(posedge clk);
    @(negedge clk) check("irq_rx3", 32'(if_a.irq), 32'd0);
    @(posedge clk); #1;
    push_rx(0, 8'hC3); rxq_a.push_back(8'hC3);
    @(negedge clk) check("irq_rx4_lag", 32'(if_a.irq), 32'd0);
    @(negedge clk) check("irq_rx4", 32'(if_a.irq), 32'd1);
    @(posedge clk); #1;
    while (rxq_a.size() != 0) begin
      rd_exp = data_exp(rxq_a.size(), rxq_a[0]);
      void'(rxq_a.pop_front());
      bus_read(0, 2'd0, d, w);
      check("irq_rx_read", d, rd_exp);
      @(negedge clk);
      check("irq_rx_after_read", 32'(if_a.irq),
            32'(re_a && rxq_a.size() >= rxth_a));
      @(posedge clk); #1;
    end
    bus_write(0, 2'd1, 32'h2); re_a = 0; we_a = 1;

    // ---- TX space interrupt: 40 queued, TX_TH=32 ----
    bus_write(0, 2'd1, 32'h0); we_a = 0;
    for (int i = 0; i < 40; i++) begin
      rdat = 8'($urandom_range(0, 255));
      bus_write(0, 2'd0, {24'd0, rdat}); txq_a.push_back(rdat);
    end
    bus_write(0, 2'd1, 32'h2); we_a = 1;
    repeat (2) @(posedge clk);
    @(negedge clk) check("irq_tx40", 32'(if_a.irq), 32'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      set_txr(0, 1'b1);
      @(negedge clk) check("tx_pulse_data", 32'(if_a.tx_data), 32'(txq_a[0]));
      @(posedge clk); #1;
      set_txr(0, 1'b0);
      void'(txq_a.pop_front());
      @(posedge clk);
      @(negedge clk) check($sformatf("irq_tx_pop%0d", k + 1), 32'(if_a.irq),
                           32'(we_a && (64 - txq_a.size()) >= txth_a));
      @(posedge clk); #1;
    end
    bus_write(0, 2'd1, 32'h0); we_a = 0;
    set_txr(0, 1'b1);
    repeat (40) @(posedge clk);
    #1 set_txr(0, 1'b0);
    txq_a.delete();
    @(negedge clk) check("tx_empty_after_drain", 32'(if_a.tx_valid), 32'd0);
    @(posedge clk); #1;

    // ---- BLOCKING=1: stall on full TX until one pop ----
    for (int i = 0; i < 4; i++) begin bus_write(1, 2'd0, 32'(i + 1)); txq_b.push_back(8'(i + 1)); end
    drive_bus(1, 1'b1, 2'd0, 1'b1, 1'b0, 32'h99);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk) check("blk_stall", 32'(if_b.avs_waitrequest), 32'd1);
    end
    @(posedge clk); #1;
    set_txr(1, 1'b1);
    @(negedge clk);
    check("blk_stall_pop_cycle", 32'(if_b.avs_waitrequest), 32'd1);
    check("blk_head", 32'(if_b.tx_data), 32'(txq_b[0]));
    @(posedge clk); #1;
    set_txr(1, 1'b0);
    void'(txq_b.pop_front());
    @(negedge clk) check("blk_release", 32'(if_b.avs_waitrequest), 32'd0);
    @(posedge clk); #1;
    drive_bus(1, 1'b0, 2'd0, 1'b1, 1'b1, 32'd0);
    txq_b.push_back(8'h99);
    bus_read(1, 2'd1, d, w);
    check("blk_ctrl", d, ctrl_exp(0, 0, 0, 0, 1, 4 - txq_b.size(), 2));
    set_txr(1, 1'b1);
    done = 0;
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clk);
      if (txq_b.size() != 0) check("blk_drain_data", 32'(if_b.tx_data), 32'(txq_b.pop_front()));
      else begin check("blk_drain_valid", 32'(if_b.tx_valid), 32'd0); done = 1; end
    end
    @(posedge clk); #1;
    set_txr(1, 1'b0);

    // ---- random concurrent RX push / CPU pop on depth-4 RX ----
    rd_phase = 0;
    rd_exp = '0;
    for (int cyc = 0; cyc < 201; cyc++) begin
      if (cyc == 200) rv = 1'b0; else rv = ($urandom_range(0, 9) < 6);
      rdat = 8'($urandom_range(0, 255));
      set_rx(1, rv, rdat);
      if (rd_phase == 1) rd_phase = 2;
      else if (cyc < 200 && $urandom_range(0, 1) == 1) begin
        drive_bus(1, 1'b1, 2'd0, 1'b0, 1'b1, 32'd0); rd_phase = 1;
      end else begin
        drive_bus(1, 1'b0, 2'd0, 1'b1, 1'b1, 32'd0); rd_phase = 0;
      end
      @(negedge clk);
      sz = rxq_b.size();
      check("rnd_rx_ready", 32'(if_b.rx_ready), 32'(sz < 4));
      if (rd_phase == 1) begin
        check("rnd_wait_c1", 32'(if_b.avs_waitrequest), 32'd1);
        rd_exp = (sz == 0) ? 32'd0 : data_exp(sz, rxq_b[0]);
        if (sz != 0) void'(rxq_b.pop_front());
      end else if (rd_phase == 2) begin
        check("rnd_wait_c2", 32'(if_b.avs_waitrequest), 32'd0);
        check("rnd_read", if_b.avs_readdata, rd_exp);
        $display("rd dut1 addr=0 data=%08h (random)", if_b.avs_readdata);
      end
      if (rv && sz < 4) rxq_b.push_back(rdat);
      @(posedge clk); #1;
    end
    drive_bus(1, 1'b0, 2'd0, 1'b1, 1'b1, 32'd0);
    set_rx(1, 1'b0, 8'd0);
    for (int k = 0; k < 5; k++) begin
      rd_exp = (rxq_b.size() == 0) ? 32'd0 : data_exp(rxq_b.size(), rxq_b[0]);
      if (rxq_b.size() != 0) void'(rxq_b.pop_front());
      bus_read(1, 2'd0, d, w);
      check("rnd_drain", d, rd_exp);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
